mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
- Multicycle MIPS control unit: sequences fetch/decode/execute for each instruction and drives the datapath's mux selects and write enables.
- It is the producer side of the ALU interface. It generates the 4-bit alucontrol code the ALU consumes and takes back the ALU zero flag for branch resolution.
- Sits between the instruction register (op/funct) and the datapath (PC, memory, register file, ALU).

Parameters:
- ALUCW, 4, width of alucontrol. Fixed codes: add 0000, sub 0001, sll 0010, srl 0011, and 0100, or 0101.
- OPW, 6, width of op and funct fields.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- op  input  6  instruction[31:26] from IR
- funct  input  6  instruction[5:0] from IR
- zero  input  1  ALU zero flag (aluout == 0)
- pcen  output  1  PC load enable = pcwrite | (branch & zero)
- memwrite  output  1  data memory write enable
- irwrite  output  1  instruction register load
- regwrite  output  1  register file write enable
- iord  output  1  memory address select: 0 PC, 1 ALUOut
- memtoreg  output  1  writeback select: 0 ALUOut, 1 MDR
- regdst  output  1  destination select: 0 rt, 1 rd
- alusrca  output  2  00 PC, 01 regA, 10 shamt (zero-extended)
- alusrcb  output  2  00 regB, 01 constant 4, 10 signext imm, 11 signext imm<<2 (zero-ext imm when zeroext=1)
- zeroext  output  1  immediate zero-extend select (andi/ori)
- pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
- alucontrol  output  4  ALU operation code
- illegal  output  1  sticky: unsupported op/funct seen

Behaviour:
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQ, IMMEX, IMMWB, JUMP. State register updates on rising clk.
- reset=1 at an edge → state=RST and illegal=0, regardless of current state (mid-instruction abort allowed). RST → FETCH unconditionally.
- All outputs are Moore-decoded from the registered state, except pcen (uses zero). Any signal not listed for a state is 0; alucontrol defaults to 0000.
- In RST every output is 0. In particular pcen=0, memwrite=0, regwrite=0.
- FETCH: iord=0, irwrite=1, alusrca=00, alusrcb=01, add, pcsrc=00, pcwrite=1. Next state DECODE.
- DECODE: alusrca=00, alusrcb=11, add (branch target precompute). Next state by op:
  - 100011 lw / 101011 sw → MEMADR
  - 000000 R-type → RTYPEEX
  - 000100 beq → BEQ
  - 001000 addi, 001100 andi, 001101 ori → IMMEX
  - 000010 j → JUMP
  - any other op → FETCH with illegal set.
- MEMADR: alusrca=01, alusrcb=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1 → MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH. MEMWR: iord=1, memwrite=1 → FETCH.
- RTYPEEX, decoded by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or: alusrca=01, alusrcb=00.
  - 000000 sll, 000010 srl: alusrca=10, alusrcb=00 (shift regB by shamt; ALU computes srca-shift-srcb semantics via operand swap handled in datapath).
  - Next state ALUWB. Unknown funct → FETCH with illegal set, no writeback.
- ALUWB: regdst=1, memtoreg=0, regwrite=1; alucontrol holds the RTYPEEX code → FETCH.
- BEQ: alusrca=01, alusrcb=00, sub, pcsrc=01, branch=1. pcen = zero in this cycle → FETCH.
- IMMEX: alusrca=01, alusrcb=10, zeroext=1 for andi/ori. Code: addi=add, andi=and, ori=or. Next state IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1, alucontrol and zeroext held → FETCH.
- JUMP: pcsrc=10, pcwrite=1 → FETCH.
- Per-instruction cycle counts: lw 5; sw 4; R-type 4; addi/andi/ori 4; beq 3; j 3; illegal 2.
- op/funct are sampled combinationally from the IR, which is stable after FETCH.
- illegal remains 1 until reset.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0 in RST; FETCH next cycle with irwrite=1, pcen=1, alucontrol=0000.
- op=000000, funct=100010 → sequence FETCH, DECODE, RTYPEEX (alucontrol=0001, alusrca=01), ALUWB (regwrite=1, regdst=1), back to FETCH in 4 cycles.
- op=000100: zero=1 in BEQ → pcen=1, pcsrc=01, alucontrol=0001. Repeat with zero=0 → pcen=0.
- op=100011 → MEMADR (alusrcb=10, add), MEMRD (iord=1), MEMWB (memtoreg=1, regwrite=1); 5 cycles total. op=101011 → memwrite=1 exactly one cycle.
- op=001101 → IMMEX with alucontrol=0101, zeroext=1; IMMWB regwrite=1, regdst=0. funct=000010 R-type → alucontrol=0011, alusrca=10.
- op=111111 → DECODE to FETCH, illegal=1 and stays 1. Reset asserted during MEMWR → next state RST, memwrite=0, illegal=0.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: walks each instruction through fetch/decode/execute states.
// Latency: outputs are Moore-decoded from the registered state; pcen also uses the zero flag.
// Backpressure: none. The controller advances one state every clock.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   op, funct            opcode/function fields from the instruction register
//   zero                 ALU zero flag, used for beq resolution
//   pcen                 PC load = pcwrite | (branch & zero)
//   memwrite, irwrite, regwrite, iord, memtoreg, regdst, zeroext
//                        datapath write enables and 1-bit selects
//   alusrca, alusrcb     ALU operand selects
//   pcsrc                next-PC select
//   alucontrol           ALU operation code
//   illegal              sticky flag for an unsupported op/funct
module mips_mc_controller #(
  parameter int ALUCW = 4,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   op,
  input  logic [OPW-1:0]   funct,
  input  logic             zero,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic             zeroext,
  output logic [1:0]       pcsrc,
  output logic [ALUCW-1:0] alucontrol,
  output logic             illegal
);

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [OPW-1:0] FN_ADD = 6'b100000;
  localparam logic [OPW-1:0] FN_SUB = 6'b100010;
  localparam logic [OPW-1:0] FN_AND = 6'b100100;
  localparam logic [OPW-1:0] FN_OR  = 6'b100101;
  localparam logic [OPW-1:0] FN_SLL = 6'b000000;
  localparam logic [OPW-1:0] FN_SRL = 6'b000010;

  localparam logic [ALUCW-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUCW-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALUCW-1:0] ALU_SLL = 4'b0010;
  localparam logic [ALUCW-1:0] ALU_SRL = 4'b0011;
  localparam logic [ALUCW-1:0] ALU_AND = 4'b0100;
  localparam logic [ALUCW-1:0] ALU_OR  = 4'b0101;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, ALUWB, BEQ, IMMEX, IMMWB, JUMP
  } state_t;

  state_t state, state_nxt;
  logic   illegal_q;
  logic   set_illegal;
  logic   pcwrite;
  logic   branch;

  // funct decode for R-type; reused in ALUWB since the IR is stable after FETCH
  logic [ALUCW-1:0] r_code;
  logic             r_valid;
  logic             r_shift;
  // immediate-op decode; reused in IMMWB for the same reason
  logic [ALUCW-1:0] i_code;
  logic             i_zext;

  always_comb begin
    r_code  = ALU_ADD;
    r_valid = 1'b1;
    r_shift = 1'b0;
    case (funct)
      FN_ADD:  r_code = ALU_ADD;
      FN_SUB:  r_code = ALU_SUB;
      FN_AND:  r_code = ALU_AND;
      FN_OR:   r_code = ALU_OR;
      FN_SLL:  begin r_code = ALU_SLL; r_shift = 1'b1; end
      FN_SRL:  begin r_code = ALU_SRL; r_shift = 1'b1; end
      default: r_valid = 1'b0;
    endcase
  end

  always_comb begin
    i_code = ALU_ADD;
    i_zext = 1'b0;
    case (op)
      OP_ANDI: begin i_code = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_code = ALU_OR;  i_zext = 1'b1; end
      default: begin i_code = ALU_ADD; i_zext = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 2'b00;
    alusrcb     = 2'b00;
    zeroext     = 1'b0;
    pcsrc       = 2'b00;
    alucontrol  = ALU_ADD;

    case (state)
      RST: state_nxt = FETCH;

      FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = 2'b01;
        pcwrite   = 1'b1;
        state_nxt = DECODE;
      end

      DECODE: begin
        // branch target precomputed into ALUOut while the op is decoded
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:             state_nxt = MEMADR;
          OP_RTYPE:                 state_nxt = RTYPEEX;
          OP_BEQ:                   state_nxt = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI: state_nxt = IMMEX;
          OP_J:                     state_nxt = JUMP;
          default: begin
            state_nxt   = FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end

      MEMADR: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        iord      = 1'b1;
        state_nxt = MEMWB;
      end

      MEMWB: begin
        memtoreg  = 1'b1;
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end

      MEMWR: begin
        iord      = 1'b1;
        memwrite  = 1'b1;
        state_nxt = FETCH;
      end

      RTYPEEX: begin
        if (r_valid) begin
          alusrca    = r_shift ? 2'b10 : 2'b01;
          alucontrol = r_code;
          state_nxt  = ALUWB;
        end else begin
          set_illegal = 1'b1;
          state_nxt   = FETCH;
        end
      end

      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        alucontrol = r_code;
        state_nxt  = FETCH;
      end

      BEQ: begin
        alusrca    = 2'b01;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_nxt  = FETCH;
      end

      IMMEX: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        zeroext    = i_zext;
        alucontrol = i_code;
        state_nxt  = IMMWB;
      end

      IMMWB: begin
        regwrite   = 1'b1;
        zeroext    = i_zext;
        alucontrol = i_code;
        state_nxt  = FETCH;
      end

      JUMP: begin
        pcsrc     = 2'b10;
        pcwrite   = 1'b1;
        state_nxt = FETCH;
      end

      default: state_nxt = RST;
    endcase
  end

  assign pcen    = pcwrite | (branch & zero);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, zeroext, illegal;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [3:0] alucontrol;

  mips_mc_controller #(.ALUCW(4), .OPW(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  outs_t got;
  assign got = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                alusrca, alusrcb, zeroext, pcsrc, alucontrol, illegal};

  // scoreboard: one expected output record per clock cycle
  outs_t exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  always @(negedge clk) begin
    outs_t e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s at %0t: got=%05h exp=%05h", nm, $time, got, e);
      end
    end
  end

  // reference model: per-instruction list of expected cycle outputs
  outs_t m_rec[8];
  string m_name[8];
  int    m_len;
  bit    m_sets_ill;
  logic  ill_m = 1'b0;

  task automatic add(input string nm, input outs_t r);
    m_rec[m_len]  = r;
    m_name[m_len] = nm;
    m_len++;
  endtask

  task automatic model(input logic [5:0] o, input logic [5:0] f, input logic z, input logic ill);
    outs_t      b, r;
    logic [3:0] code;
    bit         ok;
    m_len      = 0;
    m_sets_ill = 0;
    b          = '0;
    b.illegal  = ill;
    r = b; r.irwrite = 1'b1; r.alusrcb = 2'b01; r.pcen = 1'b1; add("fetch", r);
    r = b; r.alusrcb = 2'b11; add("decode", r);
    case (o)
      6'h23, 6'h2b: begin
        r = b; r.alusrca = 2'b01; r.alusrcb = 2'b10; add("memadr", r);
        if (o == 6'h23) begin
          r = b; r.iord = 1'b1; add("memrd", r);
          r = b; r.memtoreg = 1'b1; r.regwrite = 1'b1; add("memwb", r);
        end else begin
          r = b; r.iord = 1'b1; r.memwrite = 1'b1; add("memwr", r);
        end
      end
      6'h00: begin
        ok   = 1;
        code = 4'd0;
        case (f)
          6'h20:   code = 4'd0;
          6'h22:   code = 4'd1;
          6'h24:   code = 4'd4;
          6'h25:   code = 4'd5;
          6'h00:   code = 4'd2;
          6'h02:   code = 4'd3;
          default: ok = 0;
        endcase
        if (ok) begin
          r = b; r.alusrca = (code == 4'd2 || code == 4'd3) ? 2'b10 : 2'b01;
          r.alucontrol = code; add("rtypeex", r);
          r = b; r.regdst = 1'b1; r.regwrite = 1'b1; r.alucontrol = code; add("aluwb", r);
        end else begin
          r = b; add("rtypeex_badfunct", r);
          m_sets_ill = 1;
        end
      end
      6'h04: begin
        r = b; r.alusrca = 2'b01; r.alucontrol = 4'd1; r.pcsrc = 2'b01; r.pcen = z;
        add("beq", r);
      end
      6'h08, 6'h0c, 6'h0d: begin
        code = (o == 6'h08) ? 4'd0 : (o == 6'h0c) ? 4'd4 : 4'd5;
        r = b; r.alusrca = 2'b01; r.alusrcb = 2'b10; r.zeroext = (o != 6'h08);
        r.alucontrol = code; add("immex", r);
        r = b; r.regwrite = 1'b1; r.zeroext = (o != 6'h08); r.alucontrol = code;
        add("immwb", r);
      end
      6'h02: begin
        r = b; r.pcsrc = 2'b10; r.pcen = 1'b1; add("jump", r);
      end
      default: m_sets_ill = 1;
    endcase
  endtask

  // Called just after a rising edge; records cover the following cycles.
  // keep>0 truncates the instruction (used right before a reset abort).
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z, input int keep);
    int n;
    model(o, f, z, ill_m);
    n = (keep > 0 && keep < m_len) ? keep : m_len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_rec[i]);
      name_q.push_back(m_name[i]);
    end
    @(posedge clk); #1;
    op = o; funct = f; zero = z;
    if (n > 1) begin
      repeat (n - 1) @(posedge clk);
      #1;
    end
    if (n == m_len && m_sets_ill) ill_m = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      name_q.push_back("rst");
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ill_m = 1'b0;
  endtask

  logic [5:0] op_tab [8];
  logic [5:0] fn_tab [6];

  initial begin
    logic [5:0] o, f;
    op_tab = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h0c, 6'h0d, 6'h02};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02};

    do_reset();
    issue(6'h00, 6'h22, 1'b0, 0);  // sub
    issue(6'h04, 6'h00, 1'b1, 0);  // beq taken
    issue(6'h04, 6'h00, 1'b0, 0);  // beq not taken
    issue(6'h23, 6'h11, 1'b1, 0);  // lw
    issue(6'h2b, 6'h00, 1'b0, 0);  // sw
    issue(6'h0d, 6'h00, 1'b0, 0);  // ori
    issue(6'h00, 6'h02, 1'b1, 0);  // srl
    issue(6'h00, 6'h00, 1'b0, 0);  // sll
    issue(6'h3f, 6'h00, 1'b0, 0);  // illegal op
    issue(6'h08, 6'h00, 1'b1, 0);  // addi, illegal stays set
    issue(6'h0c, 6'h00, 1'b0, 0);  // andi
    issue(6'h2b, 6'h00, 1'b0, 4);  // sw aborted in MEMWR
    do_reset();
    issue(6'h00, 6'h3f, 1'b0, 0);  // bad funct
    issue(6'h02, 6'h00, 1'b0, 0);  // j

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        8:       o = 6'($urandom);
        9:       o = 6'h00;
        default: o = op_tab[$urandom_range(0, 7)];
      endcase
      if ($urandom_range(0, 7) == 0) f = 6'($urandom);
      else                           f = fn_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 24) == 0) begin
        issue(o, f, 1'($urandom), $urandom_range(1, 5));
        do_reset();
      end else begin
        issue(o, f, 1'($urandom), 0);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
